// File: rtl/ring_entropy_sampler.sv
// Ring-oscillator entropy sampler: synchronizes the ring, samples it on a prescaler
// tick, debiases with von Neumann pairs and delivers packed words over valid/ready.
module ring_entropy_sampler #(
   parameter int WIDTH       = 8,
   parameter int SAMPLE_DIV  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int STUCK_PAIRS = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             ring_in,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic [7:0]       drop_count,
   output logic             stuck
);

   localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int EW = $clog2(STUCK_PAIRS + 1);

   typedef enum logic {
      ST_FIRST  = 1'b0,
      ST_SECOND = 1'b1
   } pair_state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [PW-1:0]          pcnt_q, pcnt_d;
   pair_state_t            state_q, state_d;
   logic                   a_q, a_d;
   logic [WIDTH-1:0]       sr_q, sr_d;
   logic [BW-1:0]          bcnt_q, bcnt_d;
   logic [EW-1:0]          eqcnt_q, eqcnt_d;
   logic                   stuck_q, stuck_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   valid_q, valid_d;
   logic [7:0]             drop_q, drop_d;
   logic                   rs;
   logic                   tick;

   assign rs   = sync_q[SYNC_STAGES-1];
   assign tick = enable && (pcnt_q == PW'(SAMPLE_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         pcnt_q  <= '0;
         state_q <= ST_FIRST;
         a_q     <= 1'b0;
         sr_q    <= '0;
         bcnt_q  <= '0;
         eqcnt_q <= '0;
         stuck_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ring_in};
         pcnt_q  <= pcnt_d;
         state_q <= state_d;
         a_q     <= a_d;
         sr_q    <= sr_d;
         bcnt_q  <= bcnt_d;
         eqcnt_q <= eqcnt_d;
         stuck_q <= stuck_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      pcnt_d  = pcnt_q;
      state_d = state_q;
      a_d     = a_q;
      sr_d    = sr_q;
      bcnt_d  = bcnt_q;
      eqcnt_d = eqcnt_q;
      stuck_d = stuck_q;
      data_d  = data_q;
      valid_d = valid_q;
      drop_d  = drop_q;

      // A transfer retires the word; a completion below may reload it in the same cycle.
      if (valid_q && ready) begin
         valid_d = 1'b0;
      end

      if (!enable) begin
         pcnt_d  = '0;
         state_d = ST_FIRST;
         sr_d    = '0;
         bcnt_d  = '0;
         eqcnt_d = '0;
         stuck_d = 1'b0;
      end else begin
         pcnt_d = tick ? '0 : pcnt_q + 1'b1;
         if (tick) begin
            case (state_q)
               ST_FIRST: begin
                  a_d     = rs;
                  state_d = ST_SECOND;
               end
               default: begin
                  state_d = ST_FIRST;
                  if (a_q != rs) begin
                     sr_d    = {sr_q[WIDTH-2:0], a_q};
                     eqcnt_d = '0;
                     if (bcnt_q == BW'(WIDTH - 1)) begin
                        bcnt_d = '0;
                        if (!valid_q || ready) begin
                           data_d  = {sr_q[WIDTH-2:0], a_q};
                           valid_d = 1'b1;
                        end else if (drop_q != 8'hFF) begin
                           drop_d = drop_q + 8'd1;
                        end
                     end else begin
                        bcnt_d = bcnt_q + 1'b1;
                     end
                  end else begin
                     if (eqcnt_q != EW'(STUCK_PAIRS)) begin
                        eqcnt_d = eqcnt_q + 1'b1;
                     end
                     if (eqcnt_q == EW'(STUCK_PAIRS - 1)) begin
                        stuck_d = 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign drop_count = drop_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_ring_entropy_sampler.sv
// Directed bench for ring_entropy_sampler: table of pair sequences with expected words,
// plus hand sequences for backpressure, saturation, stuck detection and reset.
module tb_ring_entropy_sampler;

   localparam int WIDTH = 8;
   localparam int DIV   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             ring_in = 1'b0;
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready = 1'b0;
   logic [7:0]       drop_count;
   logic             stuck;

   int errors = 0;
   int checks = 0;

   ring_entropy_sampler #(
      .WIDTH(WIDTH), .SAMPLE_DIV(DIV), .SYNC_STAGES(2), .STUCK_PAIRS(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ring_in(ring_in),
      .data(data), .valid(valid), .ready(ready),
      .drop_count(drop_count), .stuck(stuck)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] samples;   // MSB-first sample stream
      int          nsamp;
      logic [7:0]  exp_word;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Present one ring sample and wait until the tick that captures it has passed.
   task automatic samp(input logic v);
      ring_in = v;
      repeat (DIV) @(posedge clk);
      #1;
   endtask

   task automatic pair(input logic a, input logic b);
      samp(a);
      samp(b);
   endtask

   task automatic restart();
      enable = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b1;
   endtask

   initial begin
      logic early;
      logic seen;

      vecs[0] = '{64'hAAAA,     16, 8'hFF};
      vecs[1] = '{64'h2D2D2D2D, 32, 8'hAA};
      vecs[2] = '{64'h5555,     16, 8'h00};
      vecs[3] = '{64'h95A9,     16, 8'h8E};
      vecs[4] = '{64'h6AAA,     16, 8'h7F};
      vecs[5] = '{64'hC6666,    20, 8'h55};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_data",  32'(data), 32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_drop",  32'(drop_count), 32'h0);
      chk("reset_stuck", 32'(stuck), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         restart();
         early = 1'b0;
         for (int s = 0; s < vecs[v].nsamp; s++) begin
            samp(vecs[v].samples[vecs[v].nsamp - 1 - s]);
            if (s < vecs[v].nsamp - 1) early |= valid;
         end
         chk($sformatf("vec%0d_no_early_valid", v), 32'(early), 32'h0);
         chk($sformatf("vec%0d_valid", v), 32'(valid), 32'h1);
         chk($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_word));
         chk($sformatf("vec%0d_drop", v), 32'(drop_count), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid_falls", v), 32'(valid), 32'h0);
      end

      // Backpressure: first word held, second dropped.
      ready = 1'b0;
      restart();
      for (int i = 0; i < 8; i++) pair(1'b1, 1'b0);
      chk("bp_first_valid", 32'(valid), 32'h1);
      chk("bp_first_data",  32'(data), 32'hFF);
      for (int i = 0; i < 8; i++) pair(1'b1, 1'b0);
      chk("bp_hold_data",  32'(data), 32'hFF);
      chk("bp_hold_valid", 32'(valid), 32'h1);
      chk("bp_drop1",      32'(drop_count), 32'h1);

      // Completion coincides with a transfer: new word loads, no drop.
      for (int i = 0; i < 7; i++) pair(1'b0, 1'b1);
      samp(1'b1);
      ring_in = 1'b0;
      repeat (DIV - 1) @(posedge clk);
      #1;
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      chk("simul_valid", 32'(valid), 32'h1);
      chk("simul_data",  32'(data), 32'h01);
      chk("simul_drop",  32'(drop_count), 32'h1);

      for (int w = 0; w < 253; w++)
         for (int i = 0; i < 8; i++) pair(1'b0, 1'b1);
      chk("bp_drop254", 32'(drop_count), 32'd254);
      for (int w = 0; w < 3; w++)
         for (int i = 0; i < 8; i++) pair(1'b0, 1'b1);
      chk("bp_drop_sat", 32'(drop_count), 32'd255);
      chk("bp_sat_data", 32'(data), 32'h01);
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 32'(valid), 32'h0);
      chk("bp_release_drop",  32'(drop_count), 32'd255);

      // Stuck source: ring held high.
      enable = 1'b0;
      ring_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 511; i++) begin
         @(posedge clk);
         #1;
         seen |= valid;
      end
      chk("stuck_before", 32'(stuck), 32'h0);
      @(posedge clk);
      #1;
      chk("stuck_set",      32'(stuck), 32'h1);
      chk("stuck_no_valid", 32'(seen | valid), 32'h0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("stuck_cleared", 32'(stuck), 32'h0);

      // Reset mid-pair after five emitted bits.
      restart();
      for (int i = 0; i < 5; i++) pair(1'b1, 1'b0);
      samp(1'b1);
      ring_in = 1'b0;
      repeat (2) @(posedge clk);
      #4;
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      chk("rst_data",  32'(data), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_drop",  32'(drop_count), 32'h0);
      chk("rst_stuck", 32'(stuck), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      restart();
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         pair(1'b0, 1'b1);
         seen |= valid;
      end
      chk("post_rst_no_early", 32'(seen), 32'h0);
      pair(1'b0, 1'b1);
      chk("post_rst_valid", 32'(valid), 32'h1);
      chk("post_rst_data",  32'(data), 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
